piso_serializer: RTL and testbench

Parallel-in/serial-out stage that sits directly upstream of the right-shift register. It accepts a WIDTH-bit word through a valid/ready handshake and drives it out one bit per clock on a serial line that feeds the shift register's serial input `a`. A qualifying valid flag and an end-of-word pulse are provided so the downstream register (or a checker) knows when a full word has been shifted in.

---
 rtl/serializer_pkg.sv | 23 ++
 rtl/bit_counter.sv | 25 ++
 rtl/piso_serializer.sv | 90 +++++++++
 tb/tb_piso_serializer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types and constants for the serializer/deserializer pair.
// Counter width is derived from the word length so both sides agree.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 4;

  // A WIDTH-bit word needs indices 0..WIDTH-1; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int     DEF_CNT_W  = cnt_w(DEF_WIDTH);
  localparam state_e RST_STATE  = IDLE;
  localparam logic   RST_SOUT   = 1'b0;
  localparam logic   RST_SVALID = 1'b0;
  localparam logic   RST_DONE   = 1'b0;

endpackage

// File: rtl/bit_counter.sv
// Bit-position counter with sync clear, enable and terminal-count flag.
// Holds at WIDTH-1 rather than wrapping; the owner clears it.
module bit_counter
  import serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts a word on valid/ready and shifts it
// out one bit per clock, with a qualifying valid and an end-of-word pulse.
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             live;
  logic             accept;
  logic             load;
  logic             adv;
  logic             head;

  // Held low through reset and until the first edge after release, so a
  // word presented during reset is never taken on the release edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live <= 1'b0;
    else      live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RST_STATE;
    else      state <= state_nxt;
  end

  assign in_ready = live && ((state == IDLE) || last);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        adv = 1'b1;
        if (last) begin
          if (accept) load      = 1'b1;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (load || (adv && last)),
    .en  (adv),
    .cnt (cnt),
    .tc  (last)
  );

  // Zero fill means the register is already empty once a word drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      sreg <= '0;
    else if (load) sreg <= in_data;
    else if (adv)  sreg <= LSB_FIRST ? {1'b0, sreg[WIDTH-1:1]}
                                     : {sreg[WIDTH-2:0], 1'b0};
  end

  assign head       = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
  assign sout       = (state == SHIFT) ? head : RST_SOUT;
  assign sout_valid = (state == SHIFT) ? 1'b1 : RST_SVALID;
  assign done       = (state == SHIFT) ? last : RST_DONE;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a 4-bit LSB-first and an 8-bit MSB-first
// instance checked every cycle against a bit-queue model, plus literal cases.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       iv0 = 1'b0, ir0, so0, sv0, dn0;
  logic [3:0] id0 = '0;
  logic       iv1 = 1'b0, ir1, so1, sv1, dn1;
  logic [7:0] id1 = '0;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut4 (
    .clk(clk), .rst(rst), .in_data(id0), .in_valid(iv0), .in_ready(ir0),
    .sout(so0), .sout_valid(sv0), .done(dn0)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut8 (
    .clk(clk), .rst(rst), .in_data(id1), .in_valid(iv1), .in_ready(ir1),
    .sout(so1), .sout_valid(sv1), .done(dn1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: the bits still to appear on sout, in transmit order. The head is
  // what sout shows this cycle; a single remaining bit is the done cycle.
  bit q0[$];
  bit q1[$];
  bit live = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q0.delete();
      q1.delete();
      live <= 1'b0;
    end else begin
      if (live && iv0 && q0.size() <= 1) begin
        q0.delete();
        for (int i = 0; i < 4; i++) q0.push_back(id0[i]);
      end else if (q0.size() > 0) void'(q0.pop_front());
      if (live && iv1 && q1.size() <= 1) begin
        q1.delete();
        for (int i = 0; i < 8; i++) q1.push_back(id1[7-i]);
      end else if (q1.size() > 0) void'(q1.pop_front());
      live <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("m4_ready", 32'(ir0), 32'(live && q0.size() <= 1));
    chk("m4_valid", 32'(sv0), 32'(q0.size() != 0));
    chk("m4_sout",  32'(so0), 32'((q0.size() != 0) ? q0[0] : 1'b0));
    chk("m4_done",  32'(dn0), 32'(q0.size() == 1));
    chk("m8_ready", 32'(ir1), 32'(live && q1.size() <= 1));
    chk("m8_valid", 32'(sv1), 32'(q1.size() != 0));
    chk("m8_sout",  32'(so1), 32'((q1.size() != 0) ? q1[0] : 1'b0));
    chk("m8_done",  32'(dn1), 32'(q1.size() == 1));
  end

  // Stand-in for the downstream right-shift register fed by sout.
  logic [3:0] sink = '0;
  always @(posedge clk) if (sv0) sink <= {so0, sink[3:1]};

  logic [15:0] vb, vv, vd, vr;

  initial begin
    // Reset held with a word offered: nothing moves, ready stays low.
    rst = 1'b0; iv0 = 1'b1; id0 = 4'b1010;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", 32'(ir0), 32'd0);
      chk("rst_valid", 32'(sv0), 32'd0);
      chk("rst_done",  32'(dn0), 32'd0);
      chk("rst_sout",  32'(so0), 32'd0);
    end
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rel_ready", 32'(ir0), 32'd1);
    chk("rel_idle",  32'(sv0), 32'd0);
    vb = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) iv0 = 1'b0;
      vb[i] = so0;
    end
    chk("rel_word", 32'(vb[3:0]), 32'h0000000A);
    @(negedge clk);

    // Single word
    iv0 = 1'b1; id0 = 4'b0011;
    vb = '0; vv = '0; vd = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) iv0 = 1'b0;
      vb[i] = so0; vv[i] = sv0; vd[i] = dn0;
    end
    chk("single_bits",  32'(vb[5:0]), 32'h03);
    chk("single_valid", 32'(vv[5:0]), 32'h0F);
    chk("single_done",  32'(vd[5:0]), 32'h08);
    chk("single_sink",  32'(sink),    32'h3);

    // Back-to-back words
    @(negedge clk);
    iv0 = 1'b1; id0 = 4'b0011;
    vb = '0; vv = '0; vd = '0; vr = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vb[i] = so0; vv[i] = sv0; vd[i] = dn0; vr[i] = ir0;
      if (i == 0) id0 = 4'b1100;
      if (i == 4) iv0 = 1'b0;
    end
    chk("b2b_bits",  32'(vb[9:0]), 32'h0C3);
    chk("b2b_valid", 32'(vv[9:0]), 32'h0FF);
    chk("b2b_done",  32'(vd[9:0]), 32'h088);
    chk("b2b_ready", 32'(vr[9:0]), 32'h388);

    // Offer while busy: held until the last-bit cycle
    @(negedge clk);
    iv0 = 1'b1; id0 = 4'b0011;
    vb = '0; vv = '0; vr = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vb[i] = so0; vv[i] = sv0; vr[i] = ir0;
      if (i == 0) iv0 = 1'b0;
      if (i == 1) begin iv0 = 1'b1; id0 = 4'b1111; end
      if (i == 4) iv0 = 1'b0;
    end
    chk("bp_bits",  32'(vb[9:0]), 32'h0F3);
    chk("bp_valid", 32'(vv[9:0]), 32'h0FF);
    chk("bp_ready", 32'(vr[9:0]), 32'h388);

    // Reset during the third bit, then a fresh word
    @(negedge clk);
    iv0 = 1'b1; id0 = 4'b0101;
    @(negedge clk); iv0 = 1'b0;
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("mid_sout",  32'(so0), 32'd0);
    chk("mid_valid", 32'(sv0), 32'd0);
    chk("mid_done",  32'(dn0), 32'd0);
    chk("mid_ready", 32'(ir0), 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    iv0 = 1'b1; id0 = 4'b0110;
    vb = '0; vd = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) iv0 = 1'b0;
      vb[i] = so0; vd[i] = dn0;
    end
    chk("post_rst_bits", 32'(vb[5:0]), 32'h06);
    chk("post_rst_done", 32'(vd[5:0]), 32'h08);

    // MSB-first, 8 bits
    iv1 = 1'b1; id1 = 8'hA5;
    vb = '0; vv = '0; vd = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) iv1 = 1'b0;
      vb[i] = so1; vv[i] = sv1; vd[i] = dn1;
    end
    chk("msb_bits",  32'(vb[9:0]), 32'h0A5);
    chk("msb_valid", 32'(vv[9:0]), 32'h0FF);
    chk("msb_done",  32'(vd[9:0]), 32'h080);

    // Random traffic on both instances with occasional resets
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      iv0 = ($urandom % 4) != 0;
      id0 = 4'($urandom);
      iv1 = ($urandom % 4) != 0;
      id1 = 8'($urandom);
      if (($urandom % 150) == 0) begin
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
      end
    end
    iv0 = 1'b0; iv1 = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
